clk_div_multi: RTL

Multi-channel programmable clock divider, successor to the fixed single-output divider. Each channel generates a 50%-duty divided enable-clock CLK_OUT[i] and a one-cycle TICK[i] strobe. Divide values are reloadable at runtime through a load port, and changes are applied glitch-free. Sits beside the top-level clock input and feeds slow timing domains such as display scan, debounce and CPU step.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 61 ++++++
 rtl/clk_div_multi.sv | 54 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEF   = 15;
    localparam int DEF_DIV_DEF = 20000;

    // Select-bus width; never below one bit so a single channel still has a port.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divide, toggle, tick, pend.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shd;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            act     <= DEF_V;
            shd     <= DEF_V;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            if (!run) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend) begin
                    act  <= shd;
                    pend <= 1'b0;
                end
            end else if (cnt == act) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
                tick    <= 1'b1;
                if (pend) begin
                    act  <= shd;
                    pend <= 1'b0;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
            // A load on the apply edge stays pending for the next one.
            if (ld) begin
                shd  <= ld_val;
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with glitch-free reload.
// Define CLK_DIV_MULTI_SYNC_EN to add the SYNC phase-align input.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CH      = 2,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [CH-1:0]         EN,
`ifdef CLK_DIV_MULTI_SYNC_EN
    input  logic                  SYNC,
`endif
    input  logic                  DIV_LD,
    input  logic [clog2(CH)-1:0]  DIV_SEL,
    input  logic [CNT_W-1:0]      DIV_VAL,
    output logic [CH-1:0]         CLK_OUT,
    output logic [CH-1:0]         TICK,
    output logic [CH-1:0]         LD_PEND
);

    localparam int SEL_W = clog2(CH);

    logic [CH-1:0] run;
    logic [CH-1:0] ld;

`ifdef CLK_DIV_MULTI_SYNC_EN
    // SYNC holds every channel exactly like a disable, so all restart together.
    assign run = EN & ~{CH{SYNC}};
`else
    assign run = EN;
`endif

    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign ld[i] = DIV_LD && (DIV_SEL == SEL_W'(i));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .CLK     (CLK),
            .RST_N   (RST_N),
            .run     (run[i]),
            .ld      (ld[i]),
            .ld_val  (DIV_VAL),
            .clk_out (CLK_OUT[i]),
            .tick    (TICK[i]),
            .pend    (LD_PEND[i])
        );
    end

endmodule
